model_cpu_mul_seq: RTL
======================

Name: model_cpu_mul_seq

Overview:
- Multiply sequencer for the CPU M-stage. It drives the 16x16 unsigned three-product multiplier cell (outputs p1 = a_lo*b_lo, p2 = a_lo*b_hi, p3 = a_hi*b_lo) and consumes its products.
- It assembles the 32-bit MUL low word or the MULXUU high word.
- For the high word it runs a second cell pass, feeding the upper halves into the low lanes to obtain a_hi*b_hi.
- It sits between the E-stage operand muxes and the M-stage writeback mux.

Parameters:
- None. The datapath is fixed at 32x32 unsigned, matching the 16x16 cell lanes.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- start  in  1  request a multiply; sampled only in IDLE
- op_hi  in  1  0 = MUL (low 32 bits), 1 = MULXUU (high 32 bits, unsigned)
- src_a  in  32  operand A
- src_b  in  32  operand B
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse; result valid in this cycle
- result  out  32  product word; holds its value until the next done
- cell_src1  out  32  operand to cell (E_src1)
- cell_src2  out  32  operand to cell (E_src2)
- cell_en  out  1  cell product-register enable (M_en)
- cell_p1, cell_p2, cell_p3  in  32 each  registered products from cell

Behaviour:
- Reset (async, reset_n = 0): state = IDLE, done = 0, result = 0, internal mid/op/hi-half registers = 0. Combinational outputs follow IDLE: busy = 0, cell_en = start.
- Cell model: products are registered once on an enabled edge (cell_en = 1). They are valid from the next cycle and hold while cell_en = 0.
- IDLE:
  - cell_src1 = src_a, cell_src2 = src_b, cell_en = start.
  - On start: latch op_hi, a_hi = src_a[31:16], b_hi = src_b[31:16]; go to WAIT1.
- WAIT1 (cycle T+1, p1..p3 valid):
  - MUL: result <= p1 + {(p2[15:0] + p3[15:0])[15:0], 16'h0} mod 2^32; done <= 1; next state IDLE; cell_en = 0.
  - MULXUU: mid <= p2 + p3 + (p1 >> 16) as a 34-bit zero-extended sum. Drive cell_src1 = {16'h0, a_hi}, cell_src2 = {16'h0, b_hi}, cell_en = 1; next state WAIT2.
- WAIT2 (cycle T+2; cell_p1 = a_hi*b_hi): result <= cell_p1 + mid[33:16] mod 2^32; done <= 1; next state IDLE; cell_en = 0.
- Latency (start sampled at edge ending cycle T):
  - MUL: done high in cycle T+2.
  - MULXUU: done high in cycle T+3.
  - Throughput: one op per 2 cycles (MUL) or 3 cycles (MULXUU).
- done is registered and high exactly one cycle. busy is combinational and low in the done cycle, so a start coincident with done is accepted (back-to-back issue).
- start while busy: ignored, with no effect on state or operands.
- src_a, src_b and op_hi changing while busy: no effect; operands were latched or consumed at issue.
- Reset asserted mid-operation: abort immediately. No done pulse; result returns to 0; the next op after release is computed from fresh operands.
- cell_en is never high outside the IDLE+start and WAIT1-MULXUU cycles.

Test Plan:
- MUL, src_a = 0x00010002, src_b = 0x00030004, start at T -> cell_en high in cycle T only; done in cycle T+2; result = 0x000A0008; busy high in cycle T+1 only.
- MULXUU, 0xFFFFFFFF * 0xFFFFFFFF -> cell_en high in T and T+1; cell_src1 = cell_src2 = 0x0000FFFF in T+1; done in T+3; result = 0xFFFFFFFE.
- MUL, 0xFFFFFFFF * 0xFFFFFFFF -> result = 0x00000001. Then MULXUU 0x00012345 * 0x00010000 issued in the done cycle -> accepted; result = 0x00000001 three cycles later.
- start held high continuously with alternating ops -> issues only in IDLE/done cycles. Each result matches the reference model; no extra done pulses.
- Operands changed to 0xDEADBEEF while busy during MULXUU 0x12345678 * 0x9ABCDEF0 -> result = 0x0B00EA4E (high word of 0x0B00EA4E_242D2080).
- reset_n pulsed low in cycle T+1 of a MULXUU -> busy, done and result go to 0 asynchronously; no done pulse afterwards. A following MUL 3 * 5 -> result = 0x0000000F.

Source files
------------

// File: rtl/model_cpu_mul_seq.sv
// Multiply sequencer for the M-stage: drives the 16x16 three-product cell and
// assembles either the low word (MUL) or the unsigned high word (MULXUU).
module model_cpu_mul_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op_hi,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT1 = 2'd1;
    localparam logic [1:0] WAIT2 = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        op_q, op_d;
    logic [15:0] aHi_q, aHi_d;
    logic [15:0] bHi_q, bHi_d;
    logic [33:0] mid_q, mid_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic [15:0] crossLow;
    logic [31:0] mulLow;
    logic [33:0] midSum;
    logic [31:0] mulHigh;

    // The cross products only reach the upper half of the low word, so their
    // low 16 bits are all that matter there; the high word needs the full
    // carry-preserving middle sum, which is kept for the second cell pass.
    always_comb begin
        crossLow = cell_p2[15:0] + cell_p3[15:0];
        mulLow   = cell_p1 + {crossLow, 16'h0000};
        midSum   = {2'b00, cell_p2} + {2'b00, cell_p3} + {18'h00000, cell_p1[31:16]};
        mulHigh  = cell_p1 + {14'h0000, mid_q[33:16]};
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        aHi_d     = aHi_q;
        bHi_d     = bHi_q;
        mid_d     = mid_q;
        result_d  = result_q;
        done_d    = 1'b0;
        cell_src1 = src_a;
        cell_src2 = src_b;
        cell_en   = 1'b0;
        case (state_q)
            IDLE: begin
                cell_en = start;
                if (start) begin
                    op_d    = op_hi;
                    aHi_d   = src_a[31:16];
                    bHi_d   = src_b[31:16];
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                if (op_q) begin
                    // Second pass: upper halves ride the low lanes to get a_hi*b_hi.
                    mid_d     = midSum;
                    cell_src1 = {16'h0000, aHi_q};
                    cell_src2 = {16'h0000, bHi_q};
                    cell_en   = 1'b1;
                    state_d   = WAIT2;
                end else begin
                    result_d = mulLow;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            WAIT2: begin
                result_d = mulHigh;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= 1'b0;
            aHi_q    <= 16'h0000;
            bHi_q    <= 16'h0000;
            mid_q    <= 34'h0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            aHi_q    <= aHi_d;
            bHi_q    <= bHi_d;
            mid_q    <= mid_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
